vigna_bus_arbiter: RTL and testbench

VIGNA_BUS_ARBITER -- requirements
Module: vigna_bus_arbiter

---
 rtl/vigna_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vigna_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vigna_bus_arbiter.sv
// Two-master (instruction / data) arbiter onto a single shared memory port.
// Fixed-priority or round-robin grant, one outstanding transfer, optional timeout abort.
module vigna_bus_arbiter #(
   parameter int unsigned ARB_MODE       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   output logic [31:0] d_rdata,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_addr,
   input  logic [31:0] m_rdata,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        bus_err
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   // Counter only has to reach TIMEOUT_CYCLES-1.
   localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic FIXED  = (ARB_MODE == 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_e;

   state_e              state_q,   state_d;
   logic                m_valid_q, m_valid_d;
   logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                bus_err_q, bus_err_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                last_d_q,  last_d_d;

   logic                pick_d;
   logic                expire;
   logic [DATA_W-1:0]   resp_data;

   // D wins when alone, always in fixed mode, or when I was granted last.
   assign pick_d    = d_valid && (!i_valid || FIXED || !last_d_q);
   assign expire    = TO_EN && (cnt_q == CNT_LAST);
   assign resp_data = m_ready ? m_rdata : '0;

   always_comb begin
      state_d   = state_q;
      m_valid_d = m_valid_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      i_ready_d = 1'b0;
      d_ready_d = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      bus_err_d = 1'b0;
      cnt_d     = cnt_q;
      last_d_d  = last_d_q;

      unique case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d   = BUSY_D;
               m_valid_d = 1'b1;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_wstrb_d = d_wstrb;
               cnt_d     = '0;
               last_d_d  = 1'b1;
            end else if (i_valid) begin
               state_d   = BUSY_I;
               m_valid_d = 1'b1;
               m_addr_d  = i_addr;
               m_wdata_d = '0;
               m_wstrb_d = '0;
               cnt_d     = '0;
               last_d_d  = 1'b0;
            end
         end

         BUSY_I, BUSY_D: begin
            // Completion has priority over a coincident timeout.
            if (m_ready || expire) begin
               state_d   = RESP;
               m_valid_d = 1'b0;
               bus_err_d = !m_ready;
               if (state_q == BUSY_D) begin
                  d_ready_d = 1'b1;
                  d_rdata_d = resp_data;
               end else begin
                  i_ready_d = 1'b1;
                  i_rdata_d = resp_data;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         m_valid_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         bus_err_q <= 1'b0;
         cnt_q     <= '0;
         last_d_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         bus_err_q <= bus_err_d;
         cnt_q     <= cnt_d;
         last_d_q  <= last_d_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wstrb = m_wstrb_q;
   assign i_ready = i_ready_q;
   assign d_ready = d_ready_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus and a memory responder.
module tb_vigna_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        i_valid = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_valid = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        m_ready;
   logic [31:0] m_rdata;

   logic        rr_i_ready, rr_d_ready, rr_m_valid, rr_bus_err;
   logic [31:0] rr_i_rdata, rr_d_rdata, rr_m_addr, rr_m_wdata;
   logic [3:0]  rr_m_wstrb;
   logic        fp_i_ready, fp_d_ready, fp_m_valid, fp_bus_err;
   logic [31:0] fp_i_rdata, fp_d_rdata, fp_m_addr, fp_m_wdata;
   logic [3:0]  fp_m_wstrb;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        q_rr[$];
   exp_t        q_fp[$];
   int          checks = 0;
   int          errors = 0;
   int          mem_lat = 0;
   logic [31:0] mem_data = '0;

   always #5 clk = ~clk;

   vigna_bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(rr_i_ready), .i_addr(i_addr), .i_rdata(rr_i_rdata),
      .d_valid(d_valid), .d_ready(rr_d_ready), .d_addr(d_addr), .d_rdata(rr_d_rdata),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .m_valid(rr_m_valid), .m_ready(m_ready), .m_addr(rr_m_addr), .m_rdata(m_rdata),
      .m_wdata(rr_m_wdata), .m_wstrb(rr_m_wstrb), .bus_err(rr_bus_err)
   );

   vigna_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut_fp (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(fp_i_ready), .i_addr(i_addr), .i_rdata(fp_i_rdata),
      .d_valid(d_valid), .d_ready(fp_d_ready), .d_addr(d_addr), .d_rdata(fp_d_rdata),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .m_valid(fp_m_valid), .m_ready(m_ready), .m_addr(fp_m_addr), .m_rdata(fp_m_rdata_unused_guard()),
      .m_wdata(fp_m_wdata), .m_wstrb(fp_m_wstrb), .bus_err(fp_bus_err)
   );

   function automatic logic [31:0] fp_m_rdata_unused_guard();
      return m_rdata;
   endfunction

   // Memory: ready on the mem_lat-th cycle of m_valid (0 = never), all-ones data otherwise.
   initial begin
      int bcnt;
      bcnt    = 0;
      m_ready = 1'b0;
      m_rdata = '1;
      forever begin
         @(negedge clk);
         if (rr_m_valid) begin
            if (mem_lat != 0 && bcnt == mem_lat - 1) begin
               m_ready = 1'b1;
               m_rdata = mem_data;
            end else begin
               m_ready = 1'b0;
               m_rdata = '1;
            end
            bcnt++;
         end else begin
            m_ready = 1'b0;
            m_rdata = '1;
            bcnt    = 0;
         end
      end
   end

   task automatic resp_chk(input string tag, input logic ir, input logic dr,
                           input logic [31:0] ird, input logic [31:0] drd,
                           input logic be, input logic have, input exp_t e);
      logic [31:0] act_data;
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL %s unexpected response: i_ready=%0b d_ready=%0b bus_err=%0b", tag, ir, dr, be);
      end else begin
         act_data = dr ? drd : ird;
         if (!(ir ^ dr) || dr != e.is_d || act_data !== e.rdata || be !== e.err) begin
            errors++;
            $display("FAIL %s response: actual i_ready=%0b d_ready=%0b rdata=%h bus_err=%0b, required port=%s rdata=%h bus_err=%0b",
                     tag, ir, dr, act_data, be, e.is_d ? "D" : "I", e.rdata, e.err);
         end
      end
   endtask

   // Monitor: every ready/bus_err pulse must match the oldest expected response.
   initial begin
      exp_t e;
      logic have;
      forever begin
         @(negedge clk);
         if (rr_i_ready || rr_d_ready || rr_bus_err) begin
            have = (q_rr.size() > 0);
            if (have) e = q_rr.pop_front();
            resp_chk("rr_resp", rr_i_ready, rr_d_ready, rr_i_rdata, rr_d_rdata, rr_bus_err, have, e);
         end
         if (fp_i_ready || fp_d_ready || fp_bus_err) begin
            have = (q_fp.size() > 0);
            if (have) e = q_fp.pop_front();
            resp_chk("fp_resp", fp_i_ready, fp_d_ready, fp_i_rdata, fp_d_rdata, fp_bus_err, have, e);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_both(input logic rr_d, input logic fp_d, input logic [31:0] data, input logic err);
      exp_t e;
      e.rdata = data;
      e.err   = err;
      e.is_d  = rr_d;
      q_rr.push_back(e);
      e.is_d  = fp_d;
      q_fp.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nb;

      // Reset values
      #1 resetn = 1'b0;
      #1;
      chk("rst_m_valid", 32'(rr_m_valid), 32'd0);
      chk("rst_m_addr", rr_m_addr, 32'd0);
      chk("rst_ready", 32'({rr_i_ready, rr_d_ready, rr_bus_err}), 32'd0);
      chk("rst_rdata", rr_i_rdata | rr_d_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      tick();

      // Instruction fetch, memory ready on first BUSY cycle
      mem_lat = 1; mem_data = 32'h0000_0013;
      i_valid = 1'b1; i_addr = 32'h100;
      push_both(1'b0, 1'b0, 32'h13, 1'b0);
      tick();
      i_valid = 1'b0; i_addr = 32'hBAD0;
      chk("t1_m_valid", 32'(rr_m_valid), 32'd1);
      chk("t1_m_addr", rr_m_addr, 32'h100);
      chk("t1_m_wstrb", 32'(rr_m_wstrb), 32'd0);
      chk("t1_m_wdata", rr_m_wdata, 32'd0);
      tick();
      chk("t1_m_valid_drop", 32'(rr_m_valid), 32'd0);
      chk("t1_i_ready", 32'(rr_i_ready), 32'd1);
      chk("t1_d_ready_quiet", 32'(rr_d_ready), 32'd0);
      tick();
      chk("t1_i_ready_clear", 32'(rr_i_ready), 32'd0);
      chk("t1_i_rdata_hold", rr_i_rdata, 32'h13);

      // Data write, memory ready after 3 cycles, inputs changed after grant
      mem_lat = 3; mem_data = 32'hCAFE_F00D;
      d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
      push_both(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
      tick();
      d_valid = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
      for (int k = 0; k < 3; k++) begin
         chk("t2_m_valid", 32'(rr_m_valid), 32'd1);
         chk("t2_m_addr", rr_m_addr, 32'h2000);
         chk("t2_m_wdata", rr_m_wdata, 32'hDEAD_BEEF);
         chk("t2_m_wstrb", 32'(rr_m_wstrb), 32'hF);
         tick();
      end
      chk("t2_d_ready", 32'(rr_d_ready), 32'd1);
      chk("t2_m_valid_drop", 32'(rr_m_valid), 32'd0);
      tick();
      chk("t2_d_ready_clear", 32'(rr_d_ready), 32'd0);

      // Contested requests: last grant was D, so RR goes I,D,I,D; fixed goes D x4
      mem_lat = 1; mem_data = 32'h1111_0000;
      d_wstrb = 4'h0; i_addr = 32'h300; d_addr = 32'h400;
      push_both(1'b0, 1'b1, 32'h1111_0000, 1'b0);
      push_both(1'b1, 1'b1, 32'h1111_0000, 1'b0);
      push_both(1'b0, 1'b1, 32'h1111_0000, 1'b0);
      push_both(1'b1, 1'b1, 32'h1111_0000, 1'b0);
      i_valid = 1'b1; d_valid = 1'b1;
      tick();
      chk("t3_rr_first_addr", rr_m_addr, 32'h300);
      chk("t3_fp_first_addr", fp_m_addr, 32'h400);
      n = 0;
      nb = 0;
      while (n < 4 && nb < 40) begin
         tick();
         nb++;
         if (rr_i_ready || rr_d_ready) n++;
      end
      i_valid = 1'b0; d_valid = 1'b0;
      chk("t3_resp_count", 32'(n), 32'd4);
      tick();

      // Timeout: memory never ready
      mem_lat = 0;
      d_valid = 1'b1; d_addr = 32'h500;
      push_both(1'b1, 1'b1, 32'h0, 1'b1);
      tick();
      d_valid = 1'b0;
      nb = 0;
      while (rr_m_valid && nb < 20) begin
         nb++;
         tick();
      end
      chk("t4_busy_cycles", 32'(nb), 32'd8);
      chk("t4_d_ready", 32'(rr_d_ready), 32'd1);
      chk("t4_bus_err", 32'(rr_bus_err), 32'd1);
      chk("t4_d_rdata", rr_d_rdata, 32'd0);
      tick();
      chk("t4_bus_err_clear", 32'(rr_bus_err), 32'd0);

      // Ready on the expiry cycle is a normal completion
      mem_lat = 8; mem_data = 32'h8888_0001;
      i_valid = 1'b1; i_addr = 32'h600;
      push_both(1'b0, 1'b0, 32'h8888_0001, 1'b0);
      tick();
      i_valid = 1'b0;
      nb = 0;
      while (rr_m_valid && nb < 20) begin
         nb++;
         tick();
      end
      chk("t5_busy_cycles", 32'(nb), 32'd8);
      chk("t5_bus_err", 32'(rr_bus_err), 32'd0);
      chk("t5_i_rdata", rr_i_rdata, 32'h8888_0001);
      tick();

      // Async reset in BUSY_D abandons the transfer
      mem_lat = 0;
      d_valid = 1'b1; d_addr = 32'h700; d_wdata = 32'h1234_5678; d_wstrb = 4'h3;
      tick();
      d_valid = 1'b0;
      tick();
      tick();
      chk("t6_busy_before_rst", 32'(rr_m_valid), 32'd1);
      #1 resetn = 1'b0;
      #1;
      chk("t6_m_valid_async", 32'({rr_m_valid, fp_m_valid}), 32'd0);
      chk("t6_m_addr_async", rr_m_addr, 32'd0);
      chk("t6_m_wdata_async", rr_m_wdata, 32'd0);
      chk("t6_m_wstrb_async", 32'(rr_m_wstrb), 32'd0);
      #1 resetn = 1'b1;
      repeat (3) tick();
      chk("t6_quiet", 32'({rr_m_valid, rr_d_ready, rr_i_ready}), 32'd0);

      mem_lat = 1; mem_data = 32'h0000_0077;
      push_both(1'b0, 1'b1, 32'h77, 1'b0);
      i_valid = 1'b1; d_valid = 1'b1; i_addr = 32'h800; d_addr = 32'h900;
      tick();
      i_valid = 1'b0; d_valid = 1'b0;
      chk("t6_rr_grant_i", rr_m_addr, 32'h800);
      chk("t6_fp_grant_d", fp_m_addr, 32'h900);
      tick();
      chk("t6_i_ready", 32'(rr_i_ready), 32'd1);
      repeat (3) tick();

      chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
      chk("fp_queue_drained", 32'(q_fp.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
